uart_tx_feeder: RTL

- Byte FIFO plus launch sequencer that sits directly upstream of the 9600-baud UART transmitter.
- Accepts bytes from user logic in bursts and buffers them.
- Presents one byte at a time on the transmitter's data/Tx_EN inputs, using the transmitter's RFN (ready-for-next) output as its handshake.
- Lets producers write back-to-back bytes without tracking the transmitter's ~10*CPB-cycle frame time.

---
 rtl/uart_tx_feeder.sv | 126 ++++++++++++
 1 files changed

// File: rtl/uart_tx_feeder.sv
// Byte FIFO and launch sequencer feeding a UART transmitter through its Tx_EN/RFN handshake.
// The head byte stays buffered until its frame completes, so level counts the in-flight byte.
module uart_tx_feeder #(
  parameter int unsigned DEPTH          = 16,
  parameter int unsigned AW             = 4,
  parameter int unsigned LAUNCH_TIMEOUT = 15
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [7:0]    wr_data,
  input  logic          wr_en,
  output logic          full,
  output logic [AW:0]   level,
  output logic [7:0]    tx_data,
  output logic          tx_en,
  input  logic          tx_rfn,
  output logic          overflow,
  output logic          launch_err,
  output logic          idle
);

  localparam int unsigned CW        = $clog2(LAUNCH_TIMEOUT + 1);
  localparam logic [AW:0] FullLevel = (AW+1)'(DEPTH);
  localparam logic [CW-1:0] CntLast = CW'(LAUNCH_TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StLaunch, StBusy} state_e;

  state_e        state_q, state_d;
  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [AW:0]   level_q, level_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic          overflow_q, overflow_d;
  logic          launch_err_q, launch_err_d;
  logic          push, pop;

  // Sequencer: launch while RFN is high, wait for it to fall, pop when it rises again.
  always_comb begin
    state_d      = state_q;
    cnt_d        = '0;
    tx_data_d    = tx_data_q;
    launch_err_d = launch_err_q;
    pop          = 1'b0;
    tx_en        = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (level_q != '0 && tx_rfn) begin
          tx_data_d = mem_q[rptr_q];
          state_d   = StLaunch;
        end
      end
      StLaunch: begin
        tx_en = 1'b1;
        if (!tx_rfn) begin
          state_d = StBusy;
        end else if (cnt_q == CntLast) begin
          // Transmitter never took the byte; keep it queued and retry from idle.
          launch_err_d = 1'b1;
          state_d      = StIdle;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StBusy: begin
        if (tx_rfn) begin
          pop     = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // A pop in the same cycle frees a slot, so a write while full is still accepted.
  always_comb begin
    full       = (level_q == FullLevel);
    push       = wr_en && (!full || pop);
    overflow_d = overflow_q | (wr_en & full & ~pop);
    level_d    = level_q;
    if (push && !pop) begin
      level_d = level_q + 1'b1;
    end else if (pop && !push) begin
      level_d = level_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      wptr_q       <= '0;
      rptr_q       <= '0;
      level_q      <= '0;
      cnt_q        <= '0;
      tx_data_q    <= 8'h00;
      overflow_q   <= 1'b0;
      launch_err_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      level_q      <= level_d;
      cnt_q        <= cnt_d;
      tx_data_q    <= tx_data_d;
      overflow_q   <= overflow_d;
      launch_err_q <= launch_err_d;
      if (push) begin
        wptr_q <= wptr_q + 1'b1;
      end
      if (pop) begin
        rptr_q <= rptr_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && push) begin
      mem_q[wptr_q] <= wr_data;
    end
  end

  assign level      = level_q;
  assign tx_data    = tx_data_q;
  assign overflow   = overflow_q;
  assign launch_err = launch_err_q;
  assign idle       = (level_q == '0) && (state_q == StIdle);

endmodule
